cart_mem_fetch: RTL and testbench

CART_MEM_FETCH -- requirements
Module: cart_mem_fetch

---
 rtl/cart_mem_fetch_pkg.sv | 14 +
 rtl/cart_mem_fetch_cache.sv | 38 +++
 rtl/cart_mem_fetch.sv | 153 +++++++++++++++
 tb/tb_cart_mem_fetch.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_mem_fetch_pkg.sv
// Shared cartridge definitions: fetch FSM states and the value seen on an undriven bus.
package cart_mem_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ROM_REQ  = 3'd1,
        ST_ROM_WAIT = 3'd2,
        ST_SRAM_RD  = 3'd3,
        ST_DONE     = 3'd4
    } fetch_state_e;

    localparam logic [7:0] OPEN_BUS = 8'hFF;

endpackage

// File: rtl/cart_mem_fetch_cache.sv
// One-entry ROM read cache: remembers the address and byte of the last completed SDRAM fetch.
module cart_fetch_cache #(
    parameter int ADDR_W = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fill_i,
    input  logic [ADDR_W-1:0] fill_addr_i,
    input  logic [7:0]        fill_data_i,
    input  logic [ADDR_W-1:0] lookup_addr_i,
    output logic              hit_o,
    output logic [7:0]        data_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] tag_q;
    logic [7:0]        data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
        end
    end

    // Tag and data need no reset; valid_q alone qualifies them.
    always_ff @(posedge clk) begin
        if (fill_i) begin
            tag_q  <= fill_addr_i;
            data_q <= fill_data_i;
        end
    end

    assign hit_o  = valid_q && (tag_q == lookup_addr_i);
    assign data_o = data_q;

endmodule

// File: rtl/cart_mem_fetch.sv
// Cartridge memory fetch: serves CPU reads from a one-byte ROM cache, SDRAM (toggle handshake)
// or on-chip SRAM, and CPU writes to SRAM, stretching the CPU cycle with wait_n as needed.
module cart_mem_fetch
    import cart_mem_fetch_pkg::*;
#(
    parameter int ADDR_W = 25,
    parameter int SRAM_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [7:0]        d_from_cpu,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_oe,
    input  logic [SRAM_W-1:0] sram_addr,
    input  logic              sram_oe,
    input  logic              sram_we,
    output logic [7:0]        d_to_cpu,
    output logic              wait_n,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              sdram_req,
    input  logic              sdram_ack,
    input  logic [7:0]        sdram_dout,
    output logic [SRAM_W-1:0] bram_addr,
    output logic [7:0]        bram_din,
    output logic              bram_we,
    input  logic [7:0]        bram_dout
);

    fetch_state_e      state_q, state_d;
    logic              act_q;
    logic              start;
    logic [7:0]        dout_q, dout_d;
    logic [ADDR_W-1:0] saddr_q, saddr_d;
    logic              req_q, req_d;
    logic [SRAM_W-1:0] baddr_q, baddr_d;
    logic [7:0]        bdin_q, bdin_d;
    logic              bwe_q, bwe_d;
    logic              cache_fill;
    logic              cache_hit;
    logic [7:0]        cache_data;
    logic              rd_start_wait;
    logic              busy;

    assign start = (cpu_rd || cpu_wr) && !act_q && !reset;

    cart_fetch_cache #(.ADDR_W(ADDR_W)) u_cache (
        .clk          (clk),
        .reset        (reset),
        .fill_i       (cache_fill),
        .fill_addr_i  (saddr_q),
        .fill_data_i  (sdram_dout),
        .lookup_addr_i(mem_addr),
        .hit_o        (cache_hit),
        .data_o       (cache_data)
    );

    always_comb begin
        state_d    = state_q;
        dout_d     = dout_q;
        saddr_d    = saddr_q;
        req_d      = req_q;
        baddr_d    = baddr_q;
        bdin_d     = bdin_q;
        bwe_d      = 1'b0;
        cache_fill = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Nothing is outstanding here, so track ack to swallow any late toggle.
                req_d = sdram_ack;
                if (start) begin
                    if (cpu_rd) begin
                        if (sram_oe) begin
                            baddr_d = sram_addr;
                            state_d = ST_SRAM_RD;
                        end else if (mem_oe) begin
                            if (cache_hit) begin
                                dout_d  = cache_data;
                                state_d = ST_DONE;
                            end else begin
                                state_d = ST_ROM_REQ;
                            end
                        end else begin
                            dout_d = OPEN_BUS;
                        end
                    end else if (sram_we) begin
                        bwe_d   = 1'b1;
                        baddr_d = sram_addr;
                        bdin_d  = d_from_cpu;
                    end
                end
            end
            ST_ROM_REQ: begin
                saddr_d = mem_addr;
                req_d   = ~req_q;
                state_d = ST_ROM_WAIT;
            end
            ST_ROM_WAIT: begin
                if (sdram_ack == req_q) begin
                    dout_d     = sdram_dout;
                    cache_fill = 1'b1;
                    state_d    = cpu_rd ? ST_DONE : ST_IDLE;
                end
            end
            ST_SRAM_RD: begin
                dout_d  = bram_dout;
                state_d = cpu_rd ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                if (!cpu_rd) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            act_q   <= 1'b0;
            dout_q  <= OPEN_BUS;
            saddr_q <= '0;
            req_q   <= sdram_ack;
            bwe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= cpu_rd || cpu_wr;
            dout_q  <= dout_d;
            saddr_q <= saddr_d;
            req_q   <= req_d;
            bwe_q   <= bwe_d;
        end
    end

    always_ff @(posedge clk) begin
        baddr_q <= baddr_d;
        bdin_q  <= bdin_d;
    end

    assign rd_start_wait = start && cpu_rd && (state_q == ST_IDLE) && (sram_oe || mem_oe);
    assign busy = (state_q == ST_ROM_REQ) || (state_q == ST_ROM_WAIT) || (state_q == ST_SRAM_RD);

    assign wait_n     = reset || !(rd_start_wait || busy);
    assign d_to_cpu   = dout_q;
    assign sdram_addr = saddr_q;
    assign sdram_req  = req_q;
    assign bram_we    = bwe_q;
    assign bram_din   = bdin_q;
    assign bram_addr  = ((state_q == ST_IDLE) && !bwe_q) ? sram_addr : baddr_q;

endmodule

// File: tb/tb_cart_mem_fetch.sv
// Directed bench for cart_mem_fetch with a toggle-handshake SDRAM responder and a BRAM model.
module tb_cart_mem_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rd, cpu_wr;
    logic [7:0]  d_from_cpu;
    logic [24:0] mem_addr;
    logic        mem_oe;
    logic [14:0] sram_addr;
    logic        sram_oe, sram_we;
    logic [7:0]  d_to_cpu;
    logic        wait_n;
    logic [24:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_ack = 1'b0;
    logic [7:0]  sdram_dout = 8'h00;
    logic [14:0] bram_addr;
    logic [7:0]  bram_din;
    logic        bram_we;
    logic [7:0]  bram_dout;

    int n_checks = 0;
    int n_fail = 0;
    int ack_en = 0;
    int lat = 5;
    logic [7:0] rom_data = 8'h00;
    int manual_tog = 0;
    int manual_seen = 0;
    int cnt = 0;
    int req_toggles = 0;
    logic req_prev = 1'b0;
    int t0;
    int n;

    logic [7:0] bram_mem [0:32767];

    always #5 clk = ~clk;

    cart_mem_fetch #(.ADDR_W(25), .SRAM_W(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .d_from_cpu(d_from_cpu),
        .mem_addr  (mem_addr),
        .mem_oe    (mem_oe),
        .sram_addr (sram_addr),
        .sram_oe   (sram_oe),
        .sram_we   (sram_we),
        .d_to_cpu  (d_to_cpu),
        .wait_n    (wait_n),
        .sdram_addr(sdram_addr),
        .sdram_req (sdram_req),
        .sdram_ack (sdram_ack),
        .sdram_dout(sdram_dout),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_we   (bram_we),
        .bram_dout (bram_dout)
    );

    always @(posedge clk) begin
        if (bram_we) bram_mem[bram_addr] <= bram_din;
        bram_dout <= bram_mem[bram_addr];
    end

    // SDRAM responder: acknowledges a pending request lat negedges after it appears.
    always @(negedge clk) begin
        if (manual_tog != manual_seen) begin
            manual_seen = manual_tog;
            sdram_ack = ~sdram_ack;
            sdram_dout = 8'hEE;
        end else if (ack_en != 0 && sdram_req !== sdram_ack) begin
            cnt++;
            if (cnt >= lat) begin
                sdram_ack = sdram_req;
                sdram_dout = rom_data;
                cnt = 0;
            end
        end else begin
            cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (sdram_req !== req_prev) req_toggles++;
        req_prev = sdram_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_high(output int cycles);
        cycles = 0;
        while (wait_n !== 1'b1 && cycles < 30) begin
            tick();
            cycles++;
        end
    endtask

    task automatic sram_write(input logic [14:0] a, input logic [7:0] d);
        sram_addr = a; d_from_cpu = d; sram_we = 1'b1; cpu_wr = 1'b1;
        #1;
        chk("wr_no_wait", wait_n, 1);
        tick();
        chk("wr_bram_we_on", bram_we, 1);
        chk("wr_bram_din", bram_din, d);
        chk("wr_bram_addr", bram_addr, a);
        tick();
        chk("wr_bram_we_off", bram_we, 0);
        cpu_wr = 1'b0; sram_we = 1'b0;
        tick();
    endtask

    task automatic sram_read(input logic [14:0] a, input logic both, input logic [7:0] exp);
        t0 = req_toggles;
        sram_addr = a; sram_oe = 1'b1; mem_oe = both; mem_addr = 25'h007777; cpu_rd = 1'b1;
        #1;
        chk("srd_start_wait", wait_n, 0);
        chk("srd_bram_addr", bram_addr, a);
        tick();
        chk("srd_wait_state", wait_n, 0);
        tick();
        chk("srd_done_wait", wait_n, 1);
        chk("srd_data", d_to_cpu, exp);
        cpu_rd = 1'b0; sram_oe = 1'b0; mem_oe = 1'b0;
        tick();
        chk("srd_no_sdram", req_toggles - t0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; d_from_cpu = 8'h00;
        mem_addr = '0; mem_oe = 1'b0; sram_addr = '0; sram_oe = 1'b0; sram_we = 1'b0;
        tick(); tick(); tick();
        chk("rst_wait_n", wait_n, 1);
        chk("rst_d_to_cpu", d_to_cpu, 8'hFF);
        chk("rst_bram_we", bram_we, 0);
        chk("rst_sdram_addr", sdram_addr, 0);
        chk("rst_req_eq_ack", sdram_req, sdram_ack);
        reset = 1'b0; ack_en = 1;
        tick();

        // ROM miss with a 5-cycle SDRAM response
        t0 = req_toggles; rom_data = 8'hA5; lat = 5;
        mem_addr = 25'h004123; mem_oe = 1'b1; cpu_rd = 1'b1;
        #1;
        chk("miss_start_wait", wait_n, 0);
        wait_high(n);
        chk("miss_wait_cycles", n, 7);
        chk("miss_data", d_to_cpu, 8'hA5);
        chk("miss_req_toggles", req_toggles - t0, 1);
        chk("miss_sdram_addr", sdram_addr, 25'h004123);
        cpu_rd = 1'b0; mem_oe = 1'b0;
        tick();
        chk("miss_idle_wait", wait_n, 1);
        chk("miss_data_held", d_to_cpu, 8'hA5);
        tick();

        // Repeat read hits the cache
        t0 = req_toggles; rom_data = 8'h00;
        mem_addr = 25'h004123; mem_oe = 1'b1; cpu_rd = 1'b1;
        #1;
        chk("hit_start_wait", wait_n, 0);
        tick();
        chk("hit_done_wait", wait_n, 1);
        chk("hit_data", d_to_cpu, 8'hA5);
        chk("hit_no_req", req_toggles - t0, 0);
        cpu_rd = 1'b0; mem_oe = 1'b0;
        tick(); tick();

        // Open bus read
        cpu_rd = 1'b1;
        #1;
        chk("open_no_wait", wait_n, 1);
        tick();
        chk("open_data", d_to_cpu, 8'hFF);
        cpu_rd = 1'b0;
        tick();

        // ROM write ignored
        t0 = req_toggles;
        mem_addr = 25'h000100; mem_oe = 1'b1; cpu_wr = 1'b1;
        #1;
        chk("romwr_no_wait", wait_n, 1);
        tick(); tick();
        chk("romwr_no_req", req_toggles - t0, 0);
        chk("romwr_no_bram_we", bram_we, 0);
        cpu_wr = 1'b0; mem_oe = 1'b0;
        tick();

        // SRAM write then read back; then SRAM beats ROM
        sram_write(15'h0010, 8'h3C);
        sram_read(15'h0010, 1'b0, 8'h3C);
        sram_write(15'h0020, 8'h5A);
        sram_read(15'h0020, 1'b1, 8'h5A);

        // cpu_rd dropped in ROM_WAIT, handshake still completes and fills the cache
        t0 = req_toggles; rom_data = 8'h77;
        mem_addr = 25'h00BEEF; mem_oe = 1'b1; cpu_rd = 1'b1;
        tick(); tick(); tick();
        cpu_rd = 1'b0; mem_oe = 1'b0;
        #1;
        chk("abort_still_wait", wait_n, 0);
        wait_high(n);
        chk("abort_wait_cycles", n, 4);
        chk("abort_req_toggles", req_toggles - t0, 1);
        tick();
        chk("abort_req_eq_ack", sdram_req, sdram_ack);
        t0 = req_toggles; rom_data = 8'h00;
        mem_addr = 25'h00BEEF; mem_oe = 1'b1; cpu_rd = 1'b1;
        #1;
        tick();
        chk("abort_hit_wait", wait_n, 1);
        chk("abort_hit_data", d_to_cpu, 8'h77);
        chk("abort_hit_no_req", req_toggles - t0, 0);
        cpu_rd = 1'b0; mem_oe = 1'b0;
        tick(); tick();

        // Reset in ROM_WAIT with a late ack afterwards
        ack_en = 0;
        mem_addr = 25'h012345; mem_oe = 1'b1; cpu_rd = 1'b1;
        tick(); tick(); tick();
        chk("rstmid_wait_busy", wait_n, 0);
        reset = 1'b1;
        tick();
        chk("rstmid_wait_n", wait_n, 1);
        chk("rstmid_d_to_cpu", d_to_cpu, 8'hFF);
        chk("rstmid_sdram_addr", sdram_addr, 0);
        chk("rstmid_req_eq_ack", sdram_req, sdram_ack);
        reset = 1'b0; cpu_rd = 1'b0; mem_oe = 1'b0;
        tick(); tick();
        manual_tog++;
        tick(); tick();
        chk("late_ack_idle", wait_n, 1);
        chk("late_ack_realign", sdram_req, sdram_ack);
        chk("late_ack_no_data", d_to_cpu, 8'hFF);
        ack_en = 1; rom_data = 8'h42; t0 = req_toggles;
        mem_addr = 25'h004123; mem_oe = 1'b1; cpu_rd = 1'b1;
        #1;
        chk("fresh_start_wait", wait_n, 0);
        wait_high(n);
        chk("fresh_wait_cycles", n, 7);
        chk("fresh_req_toggles", req_toggles - t0, 1);
        chk("fresh_data", d_to_cpu, 8'h42);
        cpu_rd = 1'b0; mem_oe = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
